// File: rtl/div_seq_ctrl.sv
// Iterative radix-2 restoring divider controller for DIV/DIVU in the execute stage.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iteration phase and finishes straight from PREP.
module div_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] W_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] W_ONES   = {WIDTH{1'b1}};

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        logic [WIDTH-1:0] r;
        if (neg) begin
            r = ~v + W_ONE;
        end else begin
            r = v;
        end
        return r;
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] dvnd_q, dvnd_d;
    logic             sgn_q, sgn_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   rem_sh_s;
    logic [WIDTH:0]   trial_s;

    // Next-state, datapath and output computation
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        dvnd_d      = dvnd_q;
        sgn_d       = sgn_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        dz_d        = dz_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        // Shifted partial remainder keeps the bit pushed out of rem so the trial never wraps.
        rem_sh_s    = {rem_q, quo_q[WIDTH-1]};
        trial_s     = rem_sh_s - {1'b0, dvsr_q};

        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        dvnd_d    = dividend;
                        dvsr_d    = divisor;
                        sgn_d     = is_signed;
                        neg_quo_d = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_rem_d = is_signed & dividend[WIDTH-1];
                        dz_d      = (divisor == W_ZERO);
                        state_d   = S_PREP;
                    end else begin
                        state_d   = S_IDLE;
                    end
                end
                S_PREP: begin
                    quo_d  = cond_neg(dvnd_q, sgn_q & dvnd_q[WIDTH-1]);
                    dvsr_d = cond_neg(dvsr_q, sgn_q & dvsr_q[WIDTH-1]);
                    rem_d  = W_ZERO;
                    cnt_d  = {CNT_W{1'b0}};
`ifdef DIV_ZERO_FAST_EN
                    if (dz_q) begin
                        quotient_d  = W_ONES;
                        remainder_d = dvnd_q;
                        dbz_d       = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        state_d     = S_CALC;
                    end
`else
                    state_d = S_CALC;
`endif
                end
                S_CALC: begin
                    if (!trial_s[WIDTH]) begin
                        rem_d = trial_s[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = rem_sh_s[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_FIX;
                    end else begin
                        state_d = S_CALC;
                    end
                end
                S_FIX: begin
                    // Zero divisor results override whatever the iterations produced.
                    if (dz_q) begin
                        quotient_d  = W_ONES;
                        remainder_d = dvnd_q;
                        dbz_d       = 1'b1;
                    end else begin
                        quotient_d  = cond_neg(quo_q, neg_quo_q);
                        remainder_d = cond_neg(rem_q, neg_rem_q);
                        dbz_d       = 1'b0;
                    end
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d == S_PREP) || (state_d == S_CALC) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            rem_q       <= W_ZERO;
            quo_q       <= W_ZERO;
            dvsr_q      <= W_ZERO;
            dvnd_q      <= W_ZERO;
            sgn_q       <= 1'b0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            dz_q        <= 1'b0;
            quotient_q  <= W_ZERO;
            remainder_q <= W_ZERO;
            dbz_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvsr_q      <= dvsr_d;
            dvnd_q      <= dvnd_d;
            sgn_q       <= sgn_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            dz_q        <= dz_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: arithmetic reference model plus directed vectors.
module tb_div_seq_ctrl;

    localparam int W        = 32;
    localparam int LAT_FULL = 35;
`ifdef DIV_ZERO_FAST_EN
    localparam int LAT_Z    = 2;
`else
    localparam int LAT_Z    = 35;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic         flush = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int nerr = 0;
    int nchk = 0;
    int cyc  = 0;
    int t0   = 0;

    bit           m_active = 1'b0;
    int           m_age = 0;
    int           m_lat = 0;
    logic [W-1:0] m_pq = '0, m_pr = '0, m_oq = '0, m_or = '0;
    bit           m_pz = 1'b0, m_oz = 1'b0;

    typedef struct {
        bit           s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        bit           z;
    } vec_t;

    vec_t vt[7];

    div_seq_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .flush(flush),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Truncating division from plain 64-bit arithmetic, with the divide-by-zero convention.
    function automatic void ref_div(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r, output bit z);
        longint na, nb, tq, tr;
        if (b == '0) begin
            q = '1; r = a; z = 1'b1;
        end else begin
            if (s) begin
                na = longint'($signed(a));
                nb = longint'($signed(b));
            end else begin
                na = longint'({32'h0, a});
                nb = longint'({32'h0, b});
            end
            tq = na / nb;
            tr = na % nb;
            q = tq[W-1:0];
            r = tr[W-1:0];
            z = 1'b0;
        end
    endfunction

    // Model: tracks cycles elapsed since the accepted start.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_active = 1'b0; m_oq = '0; m_or = '0; m_oz = 1'b0;
            end else if (flush) begin
                m_active = 1'b0;
            end else begin
                if (start && !(m_active && m_age < m_lat)) begin
                    ref_div(is_signed, dividend, divisor, m_pq, m_pr, m_pz);
                    m_lat    = (divisor == '0) ? LAT_Z : LAT_FULL;
                    m_active = 1'b1;
                    m_age    = 1;
                end else if (m_active) begin
                    m_age++;
                    if (m_age > m_lat) m_active = 1'b0;
                end
                if (m_active && m_age == m_lat) begin
                    m_oq = m_pq; m_or = m_pr; m_oz = m_pz;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", busy, m_active && m_age < m_lat);
            chk("done", done, m_active && m_age == m_lat);
            chk("quotient", quotient, m_oq);
            chk("remainder", remainder, m_or);
            chk("div_by_zero", div_by_zero, m_oz);
        end
    end

    task automatic launch(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1; is_signed = s; dividend = a; divisor = b;
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int elat);
        int g;
        g = 0;
        @(negedge clk);
        while (!done && g < 60) begin
            @(negedge clk);
            g++;
        end
        if (!done) begin
            nchk++; nerr++;
            $display("FAIL %s timeout: done not seen, required within %0d cycles", nm, elat);
        end else begin
            chk({nm, " latency"}, cyc - t0, elat);
        end
    endtask

    task automatic chk_res(input string nm, input logic [W-1:0] q, input logic [W-1:0] r, input bit z);
        chk({nm, " q"}, quotient, q);
        chk({nm, " r"}, remainder, r);
        chk({nm, " dbz"}, div_by_zero, z);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ndone;
        vt[0] = '{1'b0, 32'd100,       32'd7,          32'd14,         32'd2,          1'b0};
        vt[1] = '{1'b1, 32'hFFFFFFF9,  32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0};
        vt[2] = '{1'b1, 32'd7,         32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0};
        vt[3] = '{1'b1, 32'hFFFFFFF9,  32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF,   1'b0};
        vt[4] = '{1'b1, 32'h80000000,  32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0};
        vt[5] = '{1'b0, 32'hFFFFFFFF,  32'h00000010,   32'h0FFFFFFF,   32'h0000000F,   1'b0};
        vt[6] = '{1'b1, 32'h12345678,  32'd0,          32'hFFFFFFFF,   32'h12345678,   1'b1};

        #1 rst = 1'b1;
        #2;
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk_res("reset", 32'd0, 32'd0, 1'b0);
        @(negedge clk); @(negedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            launch(vt[i].s, vt[i].a, vt[i].b);
            wait_done($sformatf("vec%0d", i), (vt[i].b == '0) ? LAT_Z : LAT_FULL);
            chk_res($sformatf("vec%0d", i), vt[i].q, vt[i].r, vt[i].z);
            if (i < 6) begin
                @(posedge clk); #1;
            end
        end

        // Start issued during the DONE cycle of the previous op.
        launch(1'b0, 32'd9, 32'd3);
        wait_done("b2b", LAT_FULL);
        chk_res("b2b", 32'd3, 32'd0, 1'b0);
        @(posedge clk); #1;

        // Start while busy must be ignored.
        launch(1'b0, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1 start = 1'b1; dividend = 32'd9; divisor = 32'd3;
        @(posedge clk); #1 start = 1'b0;
        wait_done("ignore", LAT_FULL);
        chk_res("ignore", 32'd14, 32'd2, 1'b0);
        @(posedge clk); #1;

        // Flush at cycle +20 aborts without a done.
        launch(1'b1, 32'hFFFFFFF9, 32'd2);
        repeat (19) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk("flush busy", busy, 1'b0);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("flush no done", ndone, 0);
        chk_res("flush hold", 32'd14, 32'd2, 1'b0);

        // Flush and start together: nothing accepted.
        @(posedge clk); #1 start = 1'b1; flush = 1'b1; dividend = 32'd9; divisor = 32'd3;
        @(posedge clk); #1 start = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("flush+start busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        chk("flush+start done", done, 1'b0);

        // Asynchronous reset mid-CALC.
        @(posedge clk); #1;
        launch(1'b0, 32'd50, 32'd3);
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midrst busy", busy, 1'b0);
        chk("midrst done", done, 1'b0);
        chk_res("midrst", 32'd0, 32'd0, 1'b0);
        @(negedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        launch(1'b0, 32'd100, 32'd7);
        wait_done("after rst", LAT_FULL);
        chk_res("after rst", 32'd14, 32'd2, 1'b0);
        @(posedge clk); #1;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
